// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU + loader/debug) arbiter in front of a single
// memory with a fixed number of wait cycles per access.
//
// Build option:
//   MEM_ARBITER_DBG_PRIORITY_EN  defined   -> debug port wins every tie
//                                undefined -> round-robin between the ports
//
// One access runs IDLE -> ACCESS -> WAIT x WAIT_CYCLES -> DONE -> IDLE. The
// winner's command is latched in IDLE, so the requester may drop or change its
// inputs once the access has started. The loser is not queued. It is simply
// sampled again the next time the FSM is in IDLE.
//
// WAIT_CYCLES legal range is 0..15 (4-bit wait counter).

module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk_i,
  input  logic          reset_ni,

  // CPU port
  input  logic          cpu_req_i,
  input  logic [1:0]    cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,

  // Loader / debug port
  input  logic          dbg_req_i,
  input  logic [1:0]    dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_ack_o,

  // Memory side
  output logic          mem_en_o,
  output logic [1:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,

  // Status
  output logic [1:0]    stateshow_o,
  output logic          grant_o
);

  // Write-type encodings shared by both ports and the memory bus.
  localparam logic [1:0] WE_READ    = 2'b00;
  localparam logic [1:0] WE_WORD    = 2'b01;
  localparam logic [1:0] WE_BYTE    = 2'b10;
  localparam logic [1:0] WE_ILLEGAL = 2'b11;

  // Value the wait counter is loaded with in ACCESS.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // Ownership encoding used by grant_q / grant_o.
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic [1:0]    we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic          win_dbg;     // arbitration result, only meaningful in IDLE
  logic [1:0]    win_we;      // winner's write type, illegal folded to read
  logic          finish;      // this cycle is the last one with mem_en high

  // Pick the winning port from the requests seen this cycle.
  always_comb begin
    win_dbg = OWNER_CPU;
`ifdef MEM_ARBITER_DBG_PRIORITY_EN
    // The debug port wins whenever it asks.
    win_dbg = dbg_req_i;
`else
    // On a tie the port that did not own the previous access wins. grant_q
    // resets to the debug owner, so the CPU takes the first tie.
    if (cpu_req_i && dbg_req_i) begin
      win_dbg = ~grant_q;
    end else begin
      win_dbg = dbg_req_i;
    end
`endif
  end

  // Fold the illegal write type into a plain read before it is latched.
  always_comb begin
    win_we = win_dbg ? dbg_we_i : cpu_we_i;
    if (win_we == WE_ILLEGAL) begin
      win_we = WE_READ;
    end
  end

  // Next-state, datapath updates and memory/ack outputs for the access FSM.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_en_o    = 1'b0;
    mem_we_o    = WE_READ;
    cpu_ack_o   = 1'b0;
    dbg_ack_o   = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          grant_d = win_dbg;
          we_d    = win_we;
          addr_d  = win_dbg ? dbg_addr_i  : cpu_addr_i;
          wdata_d = win_dbg ? dbg_wdata_i : cpu_wdata_i;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_en_o = 1'b1;
        mem_we_o = we_q;
        cnt_d    = WAIT_LOAD;
        if (WAIT_LOAD == 4'd0) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        mem_en_o = 1'b1;
        mem_we_o = we_q;
        cnt_d    = cnt_q - 4'd1;
        // "<= 1" rather than "== 1" so a corrupted zero count cannot stall.
        if (cnt_q <= 4'd1) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        cpu_ack_o = (grant_q == OWNER_CPU);
        dbg_ack_o = (grant_q == OWNER_DBG);
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Read data is valid in the last enabled cycle; only reads update the
    // owner's read register.
    if (finish && (we_q == WE_READ)) begin
      if (grant_q == OWNER_DBG) begin
        dbg_rdata_d = mem_rdata_i;
      end else begin
        cpu_rdata_d = mem_rdata_i;
      end
    end
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= OWNER_DBG;
      we_q        <= WE_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // The bus address/data always show the last latched command.
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign stateshow_o = state_q;
  assign grant_o     = grant_q;

`ifndef SYNTHESIS
  // Only one requester can be acknowledged at a time.
  a_one_ack: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(cpu_ack_o && dbg_ack_o));

  // Each ack is a single-cycle pulse.
  a_cpu_ack_pulse: assert property (@(posedge clk_i) disable iff (!reset_ni)
    cpu_ack_o |=> !cpu_ack_o);
  a_dbg_ack_pulse: assert property (@(posedge clk_i) disable iff (!reset_ni)
    dbg_ack_o |=> !dbg_ack_o);

  // The memory bus does not move while the memory is waiting.
  a_bus_stable: assert property (@(posedge clk_i) disable iff (!reset_ni)
    (state_q == ST_WAIT) |-> ($stable(mem_addr_o) && $stable(mem_wdata_o) &&
                              $stable(mem_we_o) && mem_en_o));

  // The illegal write type never reaches the memory.
  a_no_illegal_we: assert property (@(posedge clk_i) disable iff (!reset_ni)
    mem_we_o != WE_ILLEGAL);

  // DONE always returns to IDLE.
  a_done_to_idle: assert property (@(posedge clk_i) disable iff (!reset_ni)
    (state_q == ST_DONE) |=> (state_q == ST_IDLE));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks for mem_arbiter on three instances with
// WAIT_CYCLES = 1, 0 and 3. A table of single transactions covers the main
// read/write/illegal paths. Hand-written sequences cover reset values, the
// tie-break order with both requests held, dropping a request mid-access,
// and a reset that lands in the middle of an access.
// Expectations for the tie test follow MEM_ARBITER_DBG_PRIORITY_EN.

module tb_mem_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cpu_req   [N];
  logic [1:0]  cpu_we    [N];
  logic [31:0] cpu_addr  [N];
  logic [31:0] cpu_wdata [N];
  logic [31:0] cpu_rdata [N];
  logic        cpu_ack   [N];
  logic        dbg_req   [N];
  logic [1:0]  dbg_we    [N];
  logic [31:0] dbg_addr  [N];
  logic [31:0] dbg_wdata [N];
  logic [31:0] dbg_rdata [N];
  logic        dbg_ack   [N];
  logic        mem_en    [N];
  logic [1:0]  mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic [1:0]  stateshow [N];
  logic        grant     [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned WCG = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    mem_arbiter #(.WAIT_CYCLES(WCG), .AW(32), .DW(32)) u_dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .cpu_req_i   (cpu_req[g]),
      .cpu_we_i    (cpu_we[g]),
      .cpu_addr_i  (cpu_addr[g]),
      .cpu_wdata_i (cpu_wdata[g]),
      .cpu_rdata_o (cpu_rdata[g]),
      .cpu_ack_o   (cpu_ack[g]),
      .dbg_req_i   (dbg_req[g]),
      .dbg_we_i    (dbg_we[g]),
      .dbg_addr_i  (dbg_addr[g]),
      .dbg_wdata_i (dbg_wdata[g]),
      .dbg_rdata_o (dbg_rdata[g]),
      .dbg_ack_o   (dbg_ack[g]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g]),
      .stateshow_o (stateshow[g]),
      .grant_o     (grant[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One single-port transaction with its hand-computed results.
  typedef struct {
    int          inst;
    bit          dbg_port;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rd;
    int          exp_lat;     // cycles from request sample to ack
    int          exp_en;      // cycles with mem_en high
    logic [1:0]  exp_mem_we;
    logic        exp_grant;
    logic [31:0] exp_cpu_rd;
    logic [31:0] exp_dbg_rd;
  } vec_t;

  function automatic vec_t mk(int inst, bit dbgp, logic [1:0] we, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] mem_rd, int lat, int en,
                              logic [1:0] mwe, logic gr, logic [31:0] crd, logic [31:0] drd);
    vec_t v;
    v.inst = inst;        v.dbg_port = dbgp;   v.we = we;
    v.addr = addr;        v.wdata = wdata;     v.mem_rd = mem_rd;
    v.exp_lat = lat;      v.exp_en = en;       v.exp_mem_we = mwe;
    v.exp_grant = gr;     v.exp_cpu_rd = crd;  v.exp_dbg_rd = drd;
    return v;
  endfunction

  task automatic drop_req(input int d, input bit dbgp);
    if (dbgp) dbg_req[d] = 1'b0;
    else      cpu_req[d] = 1'b0;
  endtask

  // Must be entered just after a falling edge with the DUT in IDLE; returns
  // the same way. drop_at > 0 lowers the request after that many cycles.
  task automatic run_txn(input string tag, input vec_t v, input int drop_at);
    int          d = v.inst;
    int          lat = 0;
    int          en_cnt = 0;
    int          wrong = 0;
    logic [1:0]  s_we = 2'b00;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_grant = 1'b0;
    mem_rdata[d] = v.mem_rd;
    if (v.dbg_port) begin
      dbg_req[d] = 1'b1;  dbg_we[d] = v.we;
      dbg_addr[d] = v.addr;  dbg_wdata[d] = v.wdata;
      cpu_req[d] = 1'b0;  cpu_we[d] = 2'b01;
      cpu_addr[d] = 32'hFFFF_FFF0;  cpu_wdata[d] = 32'hBAD0_BAD0;
    end else begin
      cpu_req[d] = 1'b1;  cpu_we[d] = v.we;
      cpu_addr[d] = v.addr;  cpu_wdata[d] = v.wdata;
      dbg_req[d] = 1'b0;  dbg_we[d] = 2'b10;
      dbg_addr[d] = 32'hEEEE_EEE0;  dbg_wdata[d] = 32'hBAD1_BAD1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_en[d]) begin
        en_cnt++;
        s_we = mem_we[d];  s_addr = mem_addr[d];  s_wdata = mem_wdata[d];
      end
      if (n == drop_at) drop_req(d, v.dbg_port);
      if (v.dbg_port ? cpu_ack[d] : dbg_ack[d]) wrong++;
      if (v.dbg_port ? dbg_ack[d] : cpu_ack[d]) begin
        lat = n;
        s_grant = grant[d];
        drop_req(d, v.dbg_port);
        break;
      end
    end
    drop_req(d, v.dbg_port);
    check({tag, " ack latency"}, lat, v.exp_lat);
    check({tag, " mem_en cycles"}, en_cnt, v.exp_en);
    check({tag, " mem_we"}, {30'd0, s_we}, {30'd0, v.exp_mem_we});
    check({tag, " mem_addr"}, s_addr, v.addr);
    check({tag, " mem_wdata"}, s_wdata, v.wdata);
    check({tag, " other ack"}, wrong, 0);
    check({tag, " grant"}, {31'd0, s_grant}, {31'd0, v.exp_grant});
    check({tag, " cpu_rdata"}, cpu_rdata[d], v.exp_cpu_rd);
    check({tag, " dbg_rdata"}, dbg_rdata[d], v.exp_dbg_rd);
    @(negedge clk);
    check({tag, " idle outputs"},
          {25'd0, mem_en[d], mem_we[d], stateshow[d], cpu_ack[d], dbg_ack[d]}, 32'd0);
    check({tag, " idle addr hold"}, mem_addr[d], v.addr);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   acks;
    int   overlap;
    int   ack_port [4];
    int   ack_cyc  [4];
    int   exp_port;

    // inst 0: WAIT_CYCLES=1 (latency 3, 2 enabled cycles)
    // inst 1: WAIT_CYCLES=0 (latency 2, 1 enabled cycle)
    vecs[0] = mk(0, 0, 2'b00, 32'h0000_0040, 32'h0, 32'h1234_5678, 3, 2, 2'b00, 0,
                 32'h1234_5678, 32'h0);
    vecs[1] = mk(0, 1, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 32'hAAAA_5555, 3, 2, 2'b01, 1,
                 32'h1234_5678, 32'h0);
    vecs[2] = mk(0, 0, 2'b10, 32'h0000_0044, 32'h0000_00A5, 32'hFFFF_0000, 3, 2, 2'b10, 0,
                 32'h1234_5678, 32'h0);
    vecs[3] = mk(0, 1, 2'b00, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 3, 2, 2'b00, 1,
                 32'h1234_5678, 32'hCAFE_F00D);
    vecs[4] = mk(0, 0, 2'b11, 32'h0000_0008, 32'h0, 32'h0BAD_C0DE, 3, 2, 2'b00, 0,
                 32'h0BAD_C0DE, 32'hCAFE_F00D);
    vecs[5] = mk(0, 1, 2'b11, 32'h0000_000C, 32'h0, 32'h5A5A_5A5A, 3, 2, 2'b00, 1,
                 32'h0BAD_C0DE, 32'h5A5A_5A5A);
    vecs[6] = mk(1, 1, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 32'h7777_7777, 2, 1, 2'b01, 1,
                 32'h0, 32'h0);
    vecs[7] = mk(1, 0, 2'b00, 32'h0000_003C, 32'h0, 32'h89AB_CDEF, 2, 1, 2'b00, 0,
                 32'h89AB_CDEF, 32'h0);

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      cpu_req[i] = 1'b0;  cpu_we[i] = 2'b00;  cpu_addr[i] = '0;  cpu_wdata[i] = '0;
      dbg_req[i] = 1'b0;  dbg_we[i] = 2'b00;  dbg_addr[i] = '0;  dbg_wdata[i] = '0;
      mem_rdata[i] = '0;
    end
    // Instance 1 has both ports requesting writes straight out of reset.
    cpu_req[1] = 1'b1;  cpu_we[1] = 2'b01;  cpu_addr[1] = 32'h10;  cpu_wdata[1] = 32'h1;
    dbg_req[1] = 1'b1;  dbg_we[1] = 2'b01;  dbg_addr[1] = 32'h20;  dbg_wdata[1] = 32'h2;
    mem_rdata[1] = 32'h1111_2222;

    // ---- Reset values, checked with reset still asserted ----
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset%0d state/en/we/acks", i),
            {25'd0, mem_en[i], mem_we[i], stateshow[i], cpu_ack[i], dbg_ack[i]}, 32'd0);
      check($sformatf("reset%0d grant", i), {31'd0, grant[i]}, 32'd1);
      check($sformatf("reset%0d rdata", i), cpu_rdata[i] | dbg_rdata[i], 32'd0);
      check($sformatf("reset%0d bus", i), mem_addr[i] | mem_wdata[i], 32'd0);
    end

    // ---- Both requests held from reset on instance 1 (WAIT_CYCLES=0) ----
    rst_n = 1'b1;
    acks = 0;
    overlap = 0;
    for (int n = 1; n <= 40 && acks < 4; n++) begin
      @(negedge clk);
      if (cpu_ack[1] && dbg_ack[1]) overlap++;
      if (cpu_ack[1] || dbg_ack[1]) begin
        ack_port[acks] = dbg_ack[1] ? 1 : 0;
        ack_cyc[acks]  = n;
        acks++;
      end
    end
    cpu_req[1] = 1'b0;
    dbg_req[1] = 1'b0;
    check("tie ack count", acks, 4);
    check("tie ack overlap", overlap, 0);
    for (int k = 0; k < 4 && k < acks; k++) begin
`ifdef MEM_ARBITER_DBG_PRIORITY_EN
      exp_port = 1;
`else
      exp_port = k % 2;
`endif
      check($sformatf("tie ack%0d port", k), ack_port[k], exp_port);
      check($sformatf("tie ack%0d cycle", k), ack_cyc[k], 2 + 3 * k);
    end
    @(negedge clk);
    check("tie rdata unchanged", cpu_rdata[1] | dbg_rdata[1], 32'd0);

    // ---- Table of single transactions ----
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i], 0);
    end

    // ---- CPU drops its request after the first access cycle ----
    v = mk(0, 0, 2'b00, 32'h0000_0080, 32'h0, 32'h1357_2468, 3, 2, 2'b00, 0,
           32'h1357_2468, 32'h5A5A_5A5A);
    run_txn("dropreq", v, 1);

    // ---- Reset in the second WAIT cycle on instance 2 (WAIT_CYCLES=3) ----
    cpu_req[2] = 1'b1;  cpu_we[2] = 2'b00;  cpu_addr[2] = 32'h10;
    mem_rdata[2] = 32'h0F0F_0F0F;
    @(negedge clk);
    check("abort state ACCESS", {30'd0, stateshow[2]}, 32'd1);
    @(negedge clk);
    check("abort state WAIT1", {30'd0, stateshow[2]}, 32'd2);
    @(negedge clk);
    check("abort WAIT2 en/state", {29'd0, mem_en[2], stateshow[2]}, 32'h6);
    rst_n = 1'b0;
    #1;
    check("abort immediate outputs",
          {25'd0, mem_en[2], mem_we[2], stateshow[2], cpu_ack[2], dbg_ack[2]}, 32'd0);
    check("abort rdata cleared", cpu_rdata[2], 32'd0);
    cpu_req[2] = 1'b0;
    @(negedge clk);
    check("abort no ack in reset", {31'd0, cpu_ack[2] | dbg_ack[2]}, 32'd0);
    rst_n = 1'b1;
    v = mk(2, 0, 2'b00, 32'h0000_0014, 32'h0, 32'h0F0F_0F0F, 5, 4, 2'b00, 0,
           32'h0F0F_0F0F, 32'h0);
    run_txn("post-abort", v, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra memory wait cycles per access, legal range 0..15.
REQ-002 Parameter AW, default 32: address width; DW, default 32: data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-006 cpu_we  input  2  CPU write type: 00 read, 01 word write, 10 byte write, 11 illegal.
REQ-007 cpu_addr  input  AW  CPU address; cpu_wdata  input  DW  CPU write data.
REQ-008 cpu_rdata  output  DW  CPU read data, registered; cpu_ack  output  1  CPU completion pulse.
REQ-009 dbg_req, dbg_we[1:0], dbg_addr[AW], dbg_wdata[DW] inputs; dbg_rdata[DW], dbg_ack outputs: loader/debug port, same meaning as CPU port.
REQ-010 mem_en  output  1  memory access strobe.
REQ-011 mem_we  output  2  memory write type; mem_addr  output  AW; mem_wdata  output  DW.
REQ-012 mem_rdata  input  DW  memory read data, valid in last cycle mem_en is high.
REQ-013 stateshow  output  2  current FSM state encoding, for board display.
REQ-014 grant  output  1  0 = CPU owns current/last access, 1 = debug port.

Function
REQ-015 FSM states: IDLE (00), ACCESS (01), WAIT (10), DONE (11).
REQ-016 IDLE: no request -> stay; any request -> arbitrate, latch winner's we/addr/wdata into internal registers, go ACCESS.
REQ-017 Arbitration (default build): round-robin; both requesting -> port not granted last wins; single requester always wins.
REQ-018 ACCESS: mem_en=1, mem_we/addr/wdata from latched registers; wait counter loaded with WAIT_CYCLES; WAIT_CYCLES=0 -> DONE, else -> WAIT.
REQ-019 WAIT: mem_en and bus held stable; counter decrements each cycle; counter=1 -> DONE.
REQ-020 On ACCESS/WAIT -> DONE transition, mem_rdata captured into winner's rdata register (reads only; writes leave rdata unchanged).
REQ-021 DONE: mem_en=0, mem_we=00, winner's ack=1 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Latency: request sampled in IDLE at cycle T -> ack high at cycle T+2+WAIT_CYCLES.
REQ-023 Requests not sampled in ACCESS/WAIT/DONE; req still high in IDLE after ack = new request.
REQ-024 Requester dropping req mid-access: access completes, ack still pulsed.
REQ-025 Losing requester's inputs ignored; its ack stays 0 until granted.
REQ-026 we=11 treated as read: mem_we=00, rdata updated.
REQ-027 mem_we=00 and mem_en=0 in IDLE and DONE; bus address/data outputs hold last latched values.
REQ-028 At most one ack high in any cycle.

Reset
REQ-029 reset low -> immediately: state IDLE, mem_en=0, mem_we=00, cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, latched registers 0, counter 0.
REQ-030 grant resets to 1, so CPU wins the first tie.
REQ-031 reset mid-access aborts it; no ack issued; behaviour resumes from IDLE on release.

Configuration
REQ-032 Macro MEM_ARBITER_DBG_PRIORITY_EN: defined -> debug port has fixed priority, wins every tie; undefined -> round-robin per REQ-017.

Verification
REQ-033 WAIT_CYCLES=1, cpu_req read addr 0x0000_0040, mem_rdata=0x1234_5678 -> mem_en high 2 cycles, cpu_ack at T+3, cpu_rdata=0x1234_5678.
REQ-034 WAIT_CYCLES=0, dbg word write 0xDEAD_BEEF to 0x100 -> mem_we=01 one cycle, dbg_ack at T+2, dbg_rdata unchanged.
REQ-035 Both req held continuously from reset (default build) -> grants CPU, dbg, CPU, dbg; acks alternate, never overlap.
REQ-036 Same as 035 with MEM_ARBITER_DBG_PRIORITY_EN -> dbg granted every access; cpu_ack never asserted.
REQ-037 WAIT_CYCLES=3, reset low in second WAIT cycle -> mem_en=0 and acks 0 same cycle, state IDLE; next cpu_req completes normally at T+5.
REQ-038 cpu_we=11 at 0x8 -> mem_we=00, cpu_rdata loaded from mem_rdata, cpu_ack pulsed once.
